prbs4_stream_checker: RTL
=========================

Name: prbs4_stream_checker

Overview:
- Serial consumer placed directly downstream of the 4-stage x^4+x+1 pseudo-random bit generator.
- Self-synchronises to the generator's 15-bit maximal-length sequence and declares lock.
- While locked, detects and counts bit errors.
- Used as the on-chip verification sink for the generator and for any serial link carrying its output.

Parameters:
LOCK_COUNT, 8, consecutive correct predictions required in VERIFY to enter LOCKED (>=1)
LOSS_COUNT, 3, consecutive mispredictions in LOCKED that force return to SEARCH (>=1)
ERR_W, 16, width of error counter

Ports:
clk  input  1  rising-edge clock, shared with generator
rst  input  1  synchronous active-high reset
bit_in  input  1  serial data bit (generator output)
bit_valid  input  1  bit_in is sampled only on cycles where this is 1
err_clr  input  1  synchronous clear of err_count
locked  output  1  registered; 1 while FSM in LOCKED
err_pulse  output  1  registered single-cycle pulse per counted error
err_count  output  ERR_W  saturating count of errors seen in LOCKED
period_mark  output  1  see Optional Feature

Behaviour:
- Reset (rst=1 at clk edge): FSM=SEARCH, history=0, fill/match/miss counters=0. Outputs: locked=0, err_pulse=0, err_count=0, period_mark=0. rst has priority over all other inputs, including mid-lock.
- History h[3:0]: h[0] is the newest accepted bit. prediction = h[2] XOR h[3], i.e. s[n] = s[n-3] XOR s[n-4].
  - Reference sequence from generator state 0001: 1,0,0,1,1,0,1,0,1,1,1,1,0,0,0 (period 15).
- Nothing changes on cycles with bit_valid=0, except err_clr handling. err_pulse and period_mark are 0 on those cycles.
- match = (bit_in == prediction) AND (h != 0). An all-zero window is always a mismatch, so a stuck-at-0 input never locks.
- SEARCH:
  - Each valid bit shifts into h and increments fill.
  - On the 4th valid bit, go to VERIFY with match count 0.
- VERIFY:
  - Valid bit shifts bit_in into h.
  - On match, increment match count; on the LOCK_COUNT-th consecutive match, go to LOCKED.
  - On mismatch, reset match count to 0 and stay in VERIFY.
- LOCKED (flywheel):
  - h shifts in the prediction, not bit_in, so one corrupted bit yields exactly one error.
  - On match, reset miss count.
  - On mismatch: err_pulse=1 on the next cycle, increment err_count (saturating at all-ones), increment miss count.
  - On the LOSS_COUNT-th consecutive mismatch: go to SEARCH, clearing fill, match, miss and h. That mismatch is still counted.
- Latency: all outputs are registered, one cycle after the sampling edge. locked rises on the cycle after the LOCK_COUNT-th match is sampled.
- err_clr:
  - Alone: err_count becomes 0.
  - Coincident with a counted error: err_count becomes 1.
  - Does not affect FSM or err_pulse.
- No errors are counted outside LOCKED.

Optional Feature:
- Macro: PRBS4_PERIOD_MARK_EN.
- Defined:
  - period_mark pulses for one cycle, registered, when in LOCKED and the accepted bit completes the window oldest-to-newest 0,0,0,1, i.e. h becomes 4'b0001 after the shift.
  - This gives exactly one pulse per 15 valid bits on a clean stream.
- Undefined: period_mark is tied to 0 and the comparison logic is absent.

Decomposition:
- Shared package prbs4_pkg holds:
  - FSM state encoding (SEARCH, VERIFY, LOCKED)
  - PRBS4_TAP_A=2 and PRBS4_TAP_B=3
  - PRBS4_PERIOD=15
  - PRBS4_MARK_WINDOW=4'b0001
- One natural sub-module, prbs4_predictor: 4-bit history register with load-select (bit_in vs prediction), prediction output, and zero-window flag. The FSM and counters stay in the top module.

Test Plan:
1. From reset (LOCK_COUNT=8), drive the reference sequence continuously with bit_valid=1 -> locked=1 on the cycle after the 12th bit; err_count stays 0 for 100 bits.
2. While locked, invert one bit -> err_pulse high for exactly one cycle, err_count=1, locked stays 1, no further errors.
3. While locked, invert 3 consecutive bits -> err_count=3, locked=0 on the cycle after the 3rd; resume the clean sequence -> relock after 12 valid bits.
4. Drive constant 0 for 50 bits -> locked never 1, err_count=0. Then drive constant 1 for 50 bits -> never locks.
5. Lock, then insert random bit_valid=0 gaps -> identical lock/error behaviour to the gapless case. Assert rst mid-stream -> all outputs 0 the next cycle.
6. Lock, then drive err_clr=1 on the same edge as a mismatch -> err_count=1. With PRBS4_PERIOD_MARK_EN, on a clean locked stream -> period_mark pulses every 15 valid bits.

Source files
------------

// File: rtl/prbs4_pkg.sv
// rtl/prbs4_pkg.sv - shared FSM encoding and x^4+x+1 sequence constants for the PRBS4 checker
package prbs4_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs4_state_e;

  // Prediction taps into the history window: s[n] = s[n-3] ^ s[n-4].
  localparam int         PRBS4_TAP_A       = 2;
  localparam int         PRBS4_TAP_B       = 3;
  localparam int         PRBS4_PERIOD      = 15;
  localparam logic [3:0] PRBS4_MARK_WINDOW = 4'b0001;

endpackage

// File: rtl/prbs4_predictor.sv
// rtl/prbs4_predictor.sv - 4-bit history window with next-bit prediction and zero-window flag
// mark_hit exists only when PRBS4_PERIOD_MARK_EN is defined.
module prbs4_predictor
  import prbs4_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic shift_en,
  input  logic load_pred,
  input  logic bit_in,
  output logic prediction,
  output logic zero_window
`ifdef PRBS4_PERIOD_MARK_EN
  ,
  output logic mark_hit
`endif
);

  logic [3:0] h_q;
  logic [3:0] h_d;
  logic [3:0] shifted;

  assign prediction  = h_q[PRBS4_TAP_A] ^ h_q[PRBS4_TAP_B];
  assign zero_window = (h_q == 4'b0000);

  // In flywheel mode the window is fed from its own prediction, not the line.
  assign shifted = {h_q[2:0], (load_pred ? prediction : bit_in)};

`ifdef PRBS4_PERIOD_MARK_EN
  assign mark_hit = (shifted == PRBS4_MARK_WINDOW);
`endif

  always_comb begin
    h_d = h_q;
    if (clr) begin
      h_d = 4'b0000;
    end else if (shift_en) begin
      h_d = shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= 4'b0000;
    end else begin
      h_q <= h_d;
    end
  end

endmodule

// File: rtl/prbs4_stream_checker.sv
// rtl/prbs4_stream_checker.sv - self-synchronising x^4+x+1 PRBS checker with lock FSM and error counter
// Optional period marker enabled by defining PRBS4_PERIOD_MARK_EN.
module prbs4_stream_checker
  import prbs4_pkg::*;
#(
  parameter int LOCK_COUNT = 8,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             period_mark
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(LOSS_COUNT + 1);
  localparam logic [MATCH_W-1:0] MATCH_TARGET = MATCH_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0]  MISS_TARGET  = MISS_W'(LOSS_COUNT);
  localparam logic [ERR_W-1:0]   ERR_ONE      = {{(ERR_W-1){1'b0}}, 1'b1};

  prbs4_state_e       state_q, state_d;
  logic [1:0]         fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d, match_inc;
  logic [MISS_W-1:0]  miss_q, miss_d, miss_inc;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic               err_pulse_q, err_pulse_d;
  logic               locked_q, locked_d;

  logic prediction;
  logic zero_window;
  logic match_ok;
  logic err_hit;
  logic h_shift;
  logic h_load_pred;
  logic h_clr;

`ifdef PRBS4_PERIOD_MARK_EN
  logic mark_hit;
  logic period_mark_q, period_mark_d;
`endif

  prbs4_predictor u_predictor (
    .clk         (clk),
    .rst         (rst),
    .clr         (h_clr),
    .shift_en    (h_shift),
    .load_pred   (h_load_pred),
    .bit_in      (bit_in),
    .prediction  (prediction),
    .zero_window (zero_window)
`ifdef PRBS4_PERIOD_MARK_EN
    ,
    .mark_hit    (mark_hit)
`endif
  );

  // An all-zero window never counts as a match, so stuck-at-0 cannot lock.
  assign match_ok  = (bit_in == prediction) && !zero_window;
  assign match_inc = match_q + 1'b1;
  assign miss_inc  = miss_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    match_d     = match_q;
    miss_d      = miss_q;
    h_shift     = 1'b0;
    h_load_pred = 1'b0;
    h_clr       = 1'b0;
    err_hit     = 1'b0;

    if (bit_valid) begin
      h_shift = 1'b1;
      case (state_q)
        SEARCH: begin
          fill_d = fill_q + 2'd1;
          if (fill_q == 2'd3) begin
            state_d = VERIFY;
            fill_d  = 2'd0;
            match_d = '0;
          end
        end
        VERIFY: begin
          if (match_ok) begin
            match_d = match_inc;
            if (match_inc == MATCH_TARGET) begin
              state_d = LOCKED;
              match_d = '0;
              miss_d  = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          h_load_pred = 1'b1;
          if (match_ok) begin
            miss_d = '0;
          end else begin
            err_hit = 1'b1;
            miss_d  = miss_inc;
            if (miss_inc == MISS_TARGET) begin
              state_d = SEARCH;
              fill_d  = 2'd0;
              match_d = '0;
              miss_d  = '0;
              h_clr   = 1'b1;
            end
          end
        end
        default: begin
          state_d = SEARCH;
          fill_d  = 2'd0;
          match_d = '0;
          miss_d  = '0;
          h_clr   = 1'b1;
        end
      endcase
    end

    // A clear that coincides with a counted error keeps that error.
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = err_hit ? ERR_ONE : '0;
    end else if (err_hit && !(&err_count_q)) begin
      err_count_d = err_count_q + ERR_ONE;
    end

    err_pulse_d = err_hit;
    locked_d    = (state_d == LOCKED);
  end

`ifdef PRBS4_PERIOD_MARK_EN
  always_comb begin
    period_mark_d = bit_valid && (state_q == LOCKED) && mark_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_mark_q <= 1'b0;
    end else begin
      period_mark_q <= period_mark_d;
    end
  end

  assign period_mark = period_mark_q;
`else
  assign period_mark = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      fill_q      <= 2'd0;
      match_q     <= '0;
      miss_q      <= '0;
      err_count_q <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      err_count_q <= err_count_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule
